// File: rtl/uart_receiver_if.sv
// Host-side bundle of the UART receiver: serial line, configuration, FIFO read port and status.
// Latency: none; wires only.
// Backpressure: none; the host pops via read_enable, and overflow is reported by overrun_error.
interface uart_receiver_if;
  logic       data_in;
  logic [1:0] baudrate_select;
  logic [5:0] buffer_full_threshold;
  logic       read_enable;
  logic [7:0] data_out;
  logic       buffer_empty;
  logic       buffer_full;
  logic [6:0] buffer_count;
  logic       frame_error;
  logic       overrun_error;

  // Host / line driver side
  modport master (
    output data_in, baudrate_select, buffer_full_threshold, read_enable,
    input  data_out, buffer_empty, buffer_full, buffer_count, frame_error, overrun_error
  );

  // Receiver side
  modport slave (
    input  data_in, baudrate_select, buffer_full_threshold, read_enable,
    output data_out, buffer_empty, buffer_full, buffer_count, frame_error, overrun_error
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver feeding a 64-entry first-word-fall-through byte FIFO.
// Latency: byte visible on data_out one cycle after the mid-stop-bit sample (~9.5 bit times + 4 cycles after the start edge).
// Backpressure: none on the line; a full FIFO drops the byte and pulses overrun_error unless popped the same cycle.
module uart_receiver #(
  parameter int DIVISOR_0    = 5208,
  parameter int DIVISOR_1    = 2604,
  parameter int DIVISOR_2    = 868,
  parameter int DIVISOR_3    = 434,
  parameter int BUFFER_DEPTH = 64
) (
  input logic           clock,
  input logic           reset,
  uart_receiver_if.slave bus
);

  localparam int AW   = $clog2(BUFFER_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = 13;

  localparam logic [CW-1:0]   DIV0     = CW'(DIVISOR_0);
  localparam logic [CW-1:0]   DIV1     = CW'(DIVISOR_1);
  localparam logic [CW-1:0]   DIV2     = CW'(DIVISOR_2);
  localparam logic [CW-1:0]   DIV3     = CW'(DIVISOR_3);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(BUFFER_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            prev_q, prev_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   div_q, div_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_err_q, overrun_err_d;
  logic [7:0]      mem_q [BUFFER_DEPTH];

  logic            rx_s;
  logic            push;
  logic            pop;
  logic [CW-1:0]   half_m1;
  logic [CW-1:0]   full_m1;
  logic [CNTW-1:0] thr_eff;

  assign rx_s    = sync2_q;
  assign half_m1 = {1'b0, div_q[CW-1:1]} - CW'(1);
  assign full_m1 = div_q - CW'(1);

  // Next-state: synchronizer, frame FSM, FIFO pointers and error pulses
  always_comb begin
    sync1_d       = bus.data_in;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_d         = div_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    push          = 1'b0;
    pop           = bus.read_enable && (count_q != '0);

    case (state_q)
      IDLE: begin
        // Only a fresh high-to-low transition starts a frame; a stuck-low line does not retrigger.
        if (prev_q && !rx_s) begin
          case (bus.baudrate_select)
            2'd0:    div_d = DIV0;
            2'd1:    div_d = DIV1;
            2'd2:    div_d = DIV2;
            default: div_d = DIV3;
          endcase
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == half_m1) begin
          if (!rx_s) begin
            cnt_d     = '0;
            bit_idx_d = 3'd0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == full_m1) begin
          shift_d[bit_idx_q] = rx_s;
          cnt_d              = '0;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (cnt_q == full_m1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            // A same-cycle pop frees the slot, so a full FIFO can still accept.
            if ((count_q != FULL_CNT) || pop) push = 1'b1;
            else                              overrun_err_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset; line-side flops reset to idle-high
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      prev_q        <= 1'b1;
      cnt_q         <= '0;
      div_q         <= DIV0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  // FIFO storage; contents are don't-care while count is zero, so no reset
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign thr_eff           = (bus.buffer_full_threshold == '0) ? FULL_CNT
                                                                : {1'b0, bus.buffer_full_threshold};
  assign bus.data_out      = (count_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.buffer_empty  = (count_q == '0);
  assign bus.buffer_full   = (count_q >= thr_eff);
  assign bus.buffer_count  = count_q;
  assign bus.frame_error   = frame_err_q;
  assign bus.overrun_error = overrun_err_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver, 8N1 frame format: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Received bytes are stored in an internal 64-entry FIFO and read out by the host through a read strobe.
- Receive-side counterpart of the team's UART transmitter, with matching baud-select and buffer-threshold semantics, so a TX/RX loopback runs with identical settings.

Parameters:
- DIVISOR_0, 5208, clock cycles per bit for baudrate_select=0 (9600 baud at 50 MHz).
- DIVISOR_1, 2604, clock cycles per bit for baudrate_select=1 (19200 baud).
- DIVISOR_2, 868, clock cycles per bit for baudrate_select=2 (57600 baud).
- DIVISOR_3, 434, clock cycles per bit for baudrate_select=3 (115200 baud).
- BUFFER_DEPTH, 64, FIFO entries; fixed power of two.

Ports:
- clock  input  1  single system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial line; idles high; asynchronous to clock.
- baudrate_select  input  2  selects DIVISOR_0..3; sampled only at start-bit detection.
- buffer_full_threshold  input  6  level at which buffer_full asserts; 0 means 64.
- read_enable  input  1  pops the FIFO head; ignored when empty.
- data_out  output  8  FIFO head, first-word fall-through; valid while buffer_empty=0.
- buffer_empty  output  1  FIFO count == 0.
- buffer_full  output  1  FIFO count >= effective threshold.
- buffer_count  output  7  current FIFO occupancy, 0..64.
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun_error  output  1  one-cycle pulse: valid byte dropped because FIFO full.

Behaviour:
- Reset (synchronous, active-high):
  - FSM enters IDLE; bit counter and baud counter clear.
  - Synchronizer flops and the previous-sample flop load 1.
  - FIFO pointers clear; data_out=0, buffer_empty=1, buffer_full=0, buffer_count=0, frame_error=0, overrun_error=0.
  - Reset mid-frame discards the partial byte and all FIFO contents.
- Input sync: 2-flop synchronizer on data_in gives rx_s. A previous-sample flop gives falling-edge detect: prev=1 and rx_s=0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on falling edge of rx_s, latch the divisor from baudrate_select, clear the baud counter, go to START. A line held low does not retrigger; a new high-to-low edge is required.
  - START: when the baud counter reaches divisor/2-1 (mid start bit), sample rx_s. If 0, clear the counter and go to DATA with bit index 0. If 1, treat as a glitch and return to IDLE with no flags.
  - DATA: when the counter reaches divisor-1, sample rx_s into shift register bit[index], LSB first, and clear the counter. After index 7, go to STOP.
  - STOP: when the counter reaches divisor-1, sample rx_s.
    - If 1 and FIFO not full (or read_enable pops the same cycle): push the byte.
    - If 1 and FIFO full with no pop: drop the byte and pulse overrun_error.
    - If 0: discard the byte and pulse frame_error.
    - In all cases go to IDLE.
- baudrate_select changes mid-frame have no effect until the next start detection.
- FIFO and flags:
  - Push on the stop-sample edge; the byte appears on data_out and buffer_empty falls on the following cycle.
  - Pop on read_enable with buffer_empty=0. data_out shows the next entry on the following cycle.
  - Simultaneous push and pop: both occur and count is unchanged. This includes count=64, where no overrun occurs.
  - read_enable while empty: no pop; count stays 0; no error.
  - Pointers wrap modulo 64; count is 7 bits and saturates naturally at 64.
  - buffer_full is combinational from the count register and the threshold, with threshold 0 treated as 64.
  - buffer_count, buffer_empty and buffer_full change only on clock edges.
- Error pulses last exactly one cycle and are never asserted together.

Test Plan:
- Reset, then line idle high for 100 cycles -> buffer_empty=1, buffer_count=0, data_out=0, no error pulses.
- sel=3, send 0xA5 8N1 at 434 cycles/bit -> byte pushed by 10*434+4 cycles after the start edge; data_out=0xA5, buffer_count=1. Pulse read_enable -> buffer_empty=1 next cycle.
- sel=3, 40-cycle low glitch on idle line -> START rejects, returns to IDLE; buffer_count=0, no frame_error.
- sel=2, send 0x3C with stop bit forced low, line held low 2000 cycles, then high -> exactly one frame_error pulse, no push, no retrigger until the next falling edge.
- threshold=4, send 4 bytes -> buffer_full=1 at count=4. Continue to 64 bytes; a 65th byte pulses overrun_error with count held at 64. A 66th byte with read_enable on its stop-sample cycle is accepted; count stays 64 with no overrun, and the FIFO stays in order across pointer wrap.
- Assert reset for 1 cycle mid-DATA with 3 bytes queued -> buffer_count=0, buffer_empty=1. The next full frame 0x5A is received correctly.
